brew_sequencer: RTL and testbench

//  Order-level controller for the coffee machine dispensing datapath.

---
 rtl/coffee_pkg.sv | 31 +++
 rtl/tick_prescaler.sv | 25 ++
 rtl/brew_sequencer.sv | 132 +++++++++++++
 tb/tb_brew_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/coffee_pkg.sv
// Shared types, recipe table and helpers for the coffee machine brew sequencer.
package coffee_pkg;

    localparam int N_INGR = 5;
    localparam int REC_W  = 3;

    typedef enum logic [2:0] {ESPRESSO, AMERICANO, LATTE, MOCHA, CHOCOLATE} drink_e;
    typedef enum logic [2:0] {WATER, COFFEE, SUGAR, MILK, CHOC} ingr_e;
    typedef enum logic [1:0] {IDLE, LOAD, DISPENSE, DONE} seq_state_e;

    // Seconds per ingredient, indexed [drink][ingredient], water first.
    localparam logic [REC_W-1:0] RECIPE [N_INGR][N_INGR] = '{
        '{3'd2, 3'd3, 3'd0, 3'd0, 3'd0},
        '{3'd5, 3'd2, 3'd1, 3'd0, 3'd0},
        '{3'd2, 3'd2, 3'd1, 3'd4, 3'd0},
        '{3'd2, 3'd2, 3'd1, 3'd2, 3'd3},
        '{3'd3, 3'd0, 3'd1, 3'd2, 3'd4}
    };

    function automatic logic drink_valid(input logic [2:0] code);
        return code <= CHOCOLATE;
    endfunction

    // A zero-length phase keeps every valve closed.
    function automatic logic [N_INGR-1:0] valve_for(input logic [2:0] idx, input logic open);
        logic [N_INGR-1:0] one;
        one = {{(N_INGR-1){1'b0}}, 1'b1};
        return open ? (one << idx) : '0;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into a one-cycle tick every TICK_DIV cycles in which run is high.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clock) begin
        if (!reset || clr)
            cnt <= '0;
        else if (run)
            cnt <= tick ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/brew_sequencer.sv
// Order-level brew controller: accepts a drink order and runs its five valve phases.
// Optional CUP_INTERLOCK_EN pauses dispensing and order intake while no cup is present.
module brew_sequencer
    import coffee_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int DUR_W    = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                order_valid,
    input  logic [2:0]          order_type,
    output logic                order_ready,
    input  logic                cancel,
    input  logic                cup_present,
    output logic [N_INGR-1:0]   valve,
    output logic [2:0]          step,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                err
);

    seq_state_e                     state;
    logic [N_INGR-1:0][DUR_W-1:0]   rcp;
    logic [DUR_W-1:0]               sec;
    logic [DUR_W-1:0]               cur_dur;
    logic [N_INGR-1:0]              valve_q;
    logic                           ready_q;
    logic                           cup_ok, run, tick, clr, phase_end;

`ifdef CUP_INTERLOCK_EN
    assign cup_ok      = cup_present;
    assign valve       = cup_present ? valve_q : '0;
    assign order_ready = ready_q && cup_present;
`else
    logic unused_cup;
    assign unused_cup  = cup_present;
    assign cup_ok      = 1'b1;
    assign valve       = valve_q;
    assign order_ready = ready_q;
`endif

    assign cur_dur   = rcp[step];
    assign run       = (state == DISPENSE) && cup_ok;
    assign phase_end = run && ((cur_dur == '0) || (tick && sec == cur_dur - DUR_W'(1)));
    assign clr       = (state != DISPENSE) || phase_end;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clock (clock),
        .reset (reset),
        .clr   (clr),
        .run   (run),
        .tick  (tick)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            rcp     <= '0;
            sec     <= '0;
            valve_q <= '0;
            ready_q <= 1'b0;
            step    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            err     <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            err     <= 1'b0;
            // Cancel outranks phase completion in both active states.
            if ((state == LOAD || state == DISPENSE) && cancel) begin
                state   <= IDLE;
                valve_q <= '0;
                sec     <= '0;
                step    <= '0;
                busy    <= 1'b0;
                ready_q <= 1'b1;
                aborted <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        ready_q <= 1'b1;
                        if (order_valid && order_ready) begin
                            if (drink_valid(order_type)) begin
                                for (int i = 0; i < N_INGR; i++)
                                    rcp[i] <= DUR_W'(RECIPE[order_type][i]);
                                state   <= LOAD;
                                ready_q <= 1'b0;
                                busy    <= 1'b1;
                                step    <= '0;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        state   <= DISPENSE;
                        sec     <= '0;
                        step    <= '0;
                        valve_q <= valve_for(3'd0, rcp[0] != '0);
                    end
                    DISPENSE: begin
                        if (phase_end) begin
                            sec <= '0;
                            if (step == CHOC) begin
                                state   <= DONE;
                                valve_q <= '0;
                                done    <= 1'b1;
                            end else begin
                                step    <= step + 3'd1;
                                valve_q <= valve_for(step + 3'd1, rcp[step + 3'd1] != '0);
                            end
                        end else if (run && tick) begin
                            sec <= sec + DUR_W'(1);
                        end
                    end
                    DONE: begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        step    <= '0;
                        ready_q <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_brew_sequencer.sv
// Scoreboard bench for brew_sequencer (TICK_DIV=4): expected valve segments and pulses are queued, a monitor compares.
module tb_brew_sequencer;

    localparam int K_SEG = 0, K_DONE = 1, K_ABORT = 2, K_ERR = 3;

    typedef struct {
        string nm;
        int    kind;
        int    a;
        int    b;
        int    c;
    } obs_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       order_valid = 1'b0;
    logic [2:0] order_type = '0;
    logic       cancel = 1'b0;
    logic       cup_present = 1'b1;
    logic       order_ready, busy, done, aborted, err;
    logic [4:0] valve;
    logic [2:0] step;

    brew_sequencer #(.TICK_DIV(4), .DUR_W(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .order_valid (order_valid),
        .order_type  (order_type),
        .order_ready (order_ready),
        .cancel      (cancel),
        .cup_present (cup_present),
        .valve       (valve),
        .step        (step),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .err         (err)
    );

    always #5 clock = ~clock;

    obs_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         t = 0;
    logic [4:0] prev_valve = '0;
    int         run_len = 0;
    int         run_step = 0;

    function automatic void check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endfunction

    function automatic void observe(input int kind, input int a, input int b, input int c);
        obs_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected event: got kind=%0d a=%0d b=%0d c=%0d, expected none", kind, a, b, c);
        end else begin
            e = exp_q.pop_front();
            check({e.nm, ".kind"}, kind, e.kind);
            check({e.nm, ".a"}, a, e.a);
            check({e.nm, ".b"}, b, e.b);
            check({e.nm, ".c"}, c, e.c);
        end
    endfunction

    function automatic void expect_ev(input string nm, input int kind, input int a, input int b, input int c);
        exp_q.push_back('{nm, kind, a, b, c});
    endfunction

    // t counts cycles since the accept edge: the LOAD cycle is t=1.
    always @(negedge clock) begin
        t++;
        if (valve != prev_valve) begin
            if (prev_valve != '0)
                observe(K_SEG, int'(prev_valve), run_step, run_len);
            run_len  = 0;
            run_step = int'(step);
        end
        if (valve != '0) begin
            run_len++;
            check("onehot", int'($countones(valve) == 1), 1);
        end
        prev_valve = valve;
        if (done)    observe(K_DONE, t, 0, 0);
        if (aborted) observe(K_ABORT, t, int'(order_ready), 0);
        if (err)     observe(K_ERR, int'(order_ready), int'(busy), int'(valve));
        if (order_valid && order_ready) t = 0;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic order(input int ty);
        @(posedge clock);
        #1 order_valid = 1'b1;
        order_type = 3'(ty);
        @(posedge clock);
        #1 order_valid = 1'b0;
    endtask

    task automatic check_quiet(input string nm);
        check({nm, ".valve"}, int'(valve), 0);
        check({nm, ".step"}, int'(step), 0);
        check({nm, ".busy"}, int'(busy), 0);
        check({nm, ".done"}, int'(done), 0);
        check({nm, ".aborted"}, int'(aborted), 0);
        check({nm, ".err"}, int'(err), 0);
    endtask

    task automatic expect_espresso(input string nm);
        expect_ev({nm, ".water"},  K_SEG, 1, 0, 8);
        expect_ev({nm, ".coffee"}, K_SEG, 2, 1, 12);
        expect_ev({nm, ".done"},   K_DONE, 25, 0, 0);
    endtask

    initial begin
        wait_cyc(3);
        check_quiet("reset");
        reset = 1'b1;
        wait_cyc(1);
        check("ready_after_reset", int'(order_ready), 1);

        expect_espresso("espresso");
        order(0);
        wait_cyc(30);

        expect_ev("mocha.water",  K_SEG, 1,  0, 8);
        expect_ev("mocha.coffee", K_SEG, 2,  1, 8);
        expect_ev("mocha.sugar",  K_SEG, 4,  2, 4);
        expect_ev("mocha.milk",   K_SEG, 8,  3, 8);
        expect_ev("mocha.choc",   K_SEG, 16, 4, 12);
        expect_ev("mocha.done",   K_DONE, 42, 0, 0);
        order(3);
        wait_cyc(46);

        expect_ev("bad_type.err", K_ERR, 1, 0, 0);
        order(6);
        wait_cyc(5);

        expect_ev("latte.water",  K_SEG, 1, 0, 8);
        expect_ev("latte.coffee", K_SEG, 2, 1, 8);
        expect_ev("latte.sugar",  K_SEG, 4, 2, 4);
        expect_ev("latte.milk",   K_SEG, 8, 3, 5);
        expect_ev("latte.abort",  K_ABORT, 27, 1, 0);
        order(2);
        wait_cyc(25);
        cancel = 1'b1;
        wait_cyc(1);
        cancel = 1'b0;
        wait_cyc(3);
        expect_espresso("after_cancel");
        order(0);
        wait_cyc(30);

        expect_ev("americano.water",  K_SEG, 1, 0, 20);
        expect_ev("americano.coffee", K_SEG, 2, 1, 3);
        order(1);
        wait_cyc(23);
        reset = 1'b0;
        wait_cyc(1);
        check_quiet("mid_reset");
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(3);

`ifdef CUP_INTERLOCK_EN
        expect_ev("choc.water_a", K_SEG, 1,  0, 4);
        expect_ev("choc.water_b", K_SEG, 1,  0, 8);
        expect_ev("choc.sugar",   K_SEG, 4,  2, 4);
        expect_ev("choc.milk",    K_SEG, 8,  3, 8);
        expect_ev("choc.choc",    K_SEG, 16, 4, 16);
        expect_ev("choc.done",    K_DONE, 53, 0, 0);
`else
        expect_ev("choc.water", K_SEG, 1,  0, 12);
        expect_ev("choc.sugar", K_SEG, 4,  2, 4);
        expect_ev("choc.milk",  K_SEG, 8,  3, 8);
        expect_ev("choc.choc",  K_SEG, 16, 4, 16);
        expect_ev("choc.done",  K_DONE, 43, 0, 0);
`endif
        order(4);
        wait_cyc(5);
        cup_present = 1'b0;
        wait_cyc(10);
        cup_present = 1'b1;
        wait_cyc(50);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
